// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline register (MAIN + SKID) with flush, stall and saturating bubble counter.
// Latency 1 cycle; in_ready depends on registered state only, so a full stage absorbs one extra beat.
module pipe_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 12,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  input  logic              stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic w_in_fire;
  logic w_out_fire;

  assign in_ready   = (r_state != S_FULL);
  assign out_valid  = (r_state != S_EMPTY);
  assign w_in_fire  = in_valid & in_ready & ~flush;
  assign w_out_fire = out_valid & out_ready & ~stall & ~flush;

  assign out_data   = r_main_data;
  // Bubbles must never carry RegWrite/MemWrite/Jump/Branch.
  assign out_ctrl   = out_valid ? r_main_ctrl : '0;
  assign occupancy  = r_state;
  assign bubble_cnt = r_bubble_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_EMPTY;
      r_main_data  <= '0;
      r_main_ctrl  <= '0;
      r_skid_data  <= '0;
      r_skid_ctrl  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (!out_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
      end

      if (flush) begin
        r_state     <= S_EMPTY;
        r_main_ctrl <= '0;
        r_skid_ctrl <= '0;
        if (CLEAR_DATA != 0) begin
          r_main_data <= '0;
          r_skid_data <= '0;
        end
      end else begin
        case (r_state)
          S_EMPTY: begin
            if (w_in_fire) begin
              r_main_data <= in_data;
              r_main_ctrl <= in_ctrl;
              r_state     <= S_ONE;
            end
          end
          S_ONE: begin
            if (w_in_fire && w_out_fire) begin
              r_main_data <= in_data;
              r_main_ctrl <= in_ctrl;
            end else if (w_in_fire) begin
              r_skid_data <= in_data;
              r_skid_ctrl <= in_ctrl;
              r_state     <= S_FULL;
            end else if (w_out_fire) begin
              r_state     <= S_EMPTY;
            end
          end
          S_FULL: begin
            if (w_out_fire) begin
              r_main_data <= r_skid_data;
              r_main_ctrl <= r_skid_ctrl;
              r_state     <= S_ONE;
            end
          end
          default: r_state <= S_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: default instance, a CNT_W=2 instance and a CLEAR_DATA=0 instance share stimulus.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic [11:0] in_ctrl;
  logic        flush;
  logic        stall;
  logic        out_ready;

  logic        in_ready,  out_valid;
  logic [31:0] out_data;
  logic [11:0] out_ctrl;
  logic [1:0]  occupancy;
  logic [15:0] bubble_cnt;

  logic        c2_in_ready, c2_out_valid;
  logic [31:0] c2_out_data;
  logic [11:0] c2_out_ctrl;
  logic [1:0]  c2_occupancy;
  logic [1:0]  c2_bubble_cnt;

  logic        nc_in_ready, nc_out_valid;
  logic [31:0] nc_out_data;
  logic [11:0] nc_out_ctrl;
  logic [1:0]  nc_occupancy;
  logic [15:0] nc_bubble_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .stall(stall),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.CNT_W(2)) dut_c2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c2_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .stall(stall),
    .out_valid(c2_out_valid), .out_ready(out_ready), .out_data(c2_out_data),
    .out_ctrl(c2_out_ctrl), .occupancy(c2_occupancy), .bubble_cnt(c2_bubble_cnt)
  );

  pipe_stage_reg #(.CLEAR_DATA(0)) dut_nc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nc_in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush), .stall(stall),
    .out_valid(nc_out_valid), .out_ready(out_ready), .out_data(nc_out_data),
    .out_ctrl(nc_out_ctrl), .occupancy(nc_occupancy), .bubble_cnt(nc_bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] d, input logic [11:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    flush = 1'b0; stall = 1'b0; out_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  out_data, 32'd0);
    chk("rst_out_ctrl",  {20'd0, out_ctrl}, 32'd0);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst_bubble",    {16'd0, bubble_cnt}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);

    // Nothing is captured while reset is held, even with a valid offer.
    offer(1'b1, 32'hDEAD, 12'h001);
    tick();
    chk("rst_no_capture", {30'd0, occupancy}, 32'd0);
    offer(1'b0, 32'd0, 12'd0);
    tick();
    reset = 1'b1;
    chk("rel_bubble0", {16'd0, bubble_cnt}, 32'd0);

    // Five idle edges after release.
    for (int i = 0; i < 5; i++) tick();
    chk("idle5_bubble",    {16'd0, bubble_cnt}, 32'd5);
    chk("idle5_c2_bubble", {30'd0, c2_bubble_cnt}, 32'd3);

    // Streaming 0x100..0x10F at one per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      offer(1'b1, 32'h100 + i, 12'(i + 1));
      tick();
      chk($sformatf("stream_data_%0d", i), out_data, 32'h100 + i);
      chk($sformatf("stream_ctrl_%0d", i), {20'd0, out_ctrl}, 32'(i + 1));
      chk($sformatf("stream_occ_%0d", i), {30'd0, occupancy}, 32'd1);
      chk($sformatf("stream_rdy_%0d", i), {31'd0, in_ready}, 32'd1);
    end
    offer(1'b0, 32'd0, 12'd0);
    tick();
    chk("drain_valid",  {31'd0, out_valid}, 32'd0);
    chk("drain_ctrl",   {20'd0, out_ctrl}, 32'd0);
    chk("drain_bubble", {16'd0, bubble_cnt}, 32'd6);
    chk("c2_sat_hold",  {30'd0, c2_bubble_cnt}, 32'd3);

    // Backpressure: A, B fill the stage, C is held off until release.
    out_ready = 1'b0;
    offer(1'b1, 32'hA, 12'h00A);
    tick();
    chk("bp_occ1",  {30'd0, occupancy}, 32'd1);
    chk("bp_dataA", out_data, 32'hA);
    offer(1'b1, 32'hB, 12'h00B);
    tick();
    chk("bp_occ2",  {30'd0, occupancy}, 32'd2);
    chk("bp_rdy0",  {31'd0, in_ready}, 32'd0);
    offer(1'b1, 32'hC, 12'h00C);
    tick();
    chk("bp_hold_occ",  {30'd0, occupancy}, 32'd2);
    chk("bp_hold_data", out_data, 32'hA);
    out_ready = 1'b1;
    tick();
    chk("bp_outB",  out_data, 32'hB);
    chk("bp_ctrlB", {20'd0, out_ctrl}, 32'h00B);
    chk("bp_occB",  {30'd0, occupancy}, 32'd1);
    tick();
    chk("bp_outC",  out_data, 32'hC);
    chk("bp_validC", {31'd0, out_valid}, 32'd1);
    offer(1'b0, 32'd0, 12'd0);
    tick();
    chk("bp_empty", {30'd0, occupancy}, 32'd0);

    // Stall with out_ready=1: stage absorbs two entries and holds them.
    stall = 1'b1;
    offer(1'b1, 32'h20, 12'h005);
    tick();
    offer(1'b1, 32'h21, 12'h006);
    tick();
    offer(1'b0, 32'd0, 12'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_data_%0d", i), out_data, 32'h20);
      chk($sformatf("stall_occ_%0d", i), {30'd0, occupancy}, 32'd2);
    end
    stall = 1'b0;
    tick();
    chk("unstall_data", out_data, 32'h21);
    chk("unstall_occ",  {30'd0, occupancy}, 32'd1);
    tick();
    chk("unstall_empty", {31'd0, out_valid}, 32'd0);

    // Flush while FULL with a 0xFFF control offer pending.
    out_ready = 1'b0;
    offer(1'b1, 32'h30, 12'h007);
    tick();
    offer(1'b1, 32'h31, 12'h008);
    tick();
    chk("pre_flush_occ", {30'd0, occupancy}, 32'd2);
    offer(1'b1, 32'h55, 12'hFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 32'd0, 12'd0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ctrl",  {20'd0, out_ctrl}, 32'd0);
    chk("flush_data",  out_data, 32'd0);
    chk("flush_occ",   {30'd0, occupancy}, 32'd0);
    chk("flush_nc_data", nc_out_data, 32'h30);
    chk("flush_nc_ctrl", {20'd0, nc_out_ctrl}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("flush_dropped", {31'd0, out_valid}, 32'd0);

    // Flush in ONE drops an instruction that would otherwise be accepted.
    out_ready = 1'b0;
    offer(1'b1, 32'h40, 12'h009);
    tick();
    offer(1'b1, 32'h41, 12'hFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    offer(1'b0, 32'd0, 12'd0);
    tick();
    chk("flush_one_occ",  {30'd0, occupancy}, 32'd0);
    chk("flush_one_ctrl", {20'd0, out_ctrl}, 32'd0);

    // Asynchronous reset pulse between edges while FULL.
    offer(1'b1, 32'h60, 12'h00D);
    tick();
    offer(1'b1, 32'h61, 12'h00E);
    tick();
    offer(1'b0, 32'd0, 12'd0);
    chk("pre_arst_occ", {30'd0, occupancy}, 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid",  {31'd0, out_valid}, 32'd0);
    chk("arst_data",   out_data, 32'd0);
    chk("arst_ctrl",   {20'd0, out_ctrl}, 32'd0);
    chk("arst_occ",    {30'd0, occupancy}, 32'd0);
    chk("arst_rdy",    {31'd0, in_ready}, 32'd1);
    chk("arst_bubble", {16'd0, bubble_cnt}, 32'd0);

    offer(1'b1, 32'h70, 12'h00F);
    tick();
    chk("arst_no_capture", {30'd0, occupancy}, 32'd0);
    reset = 1'b1;
    tick();
    chk("first_capture_data", out_data, 32'h70);
    chk("first_capture_occ",  {30'd0, occupancy}, 32'd1);
    offer(1'b0, 32'd0, 12'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
